// File: rtl/frame_capture_writer.sv
// frame_capture_writer: on a PC request flushes the FIFO, then writes one camera frame into it
module frame_capture_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cap_req,
  input  logic        cap_abort,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel,
  input  logic        fifo_full,
  output logic        fifo_wr_enable,
  output logic [31:0] fifo_data_in,
  output logic        fifo_write_reset,
  output logic        busy,
  output logic        done,
  output logic [31:0] status
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    WAIT_IDLE = 3'd2,
    WAIT_SOF  = 3'd3,
    CAPTURE   = 3'd4,
    DONE      = 3'd5
  } state_t;
  localparam int FW = $clog2(RST_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RST_CYCLES - 1);
  localparam logic [15:0] H_END = 16'(H_ACTIVE);
  localparam logic [15:0] V_END = 16'(V_ACTIVE);
  localparam logic [18:0] PW_MAX = '1;
  logic fv_r, lv_r, pv_r, req_r, fv_p, lv_p, req_p;
  logic [7:0] pix_r;
  state_t state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic to_idle_q, to_idle_d;
  logic [15:0] col_q, col_d, line_q, line_d;
  logic [18:0] pw_q, pw_d;
  logic ovf_q, ovf_d, size_q, size_d;
  logic wr_q, wr_d, frst_q, frst_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] data_q, data_d, status_q, status_d;
  logic accept, in_range, line_end, frame_end, req_rise;
  assign accept    = (state_q == CAPTURE || (state_q == WAIT_SOF && fv_r)) && lv_r && pv_r;
  assign in_range  = col_q < H_END && line_q < V_END;
  assign line_end  = state_q == CAPTURE && ((lv_p && !lv_r) || (fv_p && !fv_r));
  assign frame_end = state_q == CAPTURE && fv_p && !fv_r;
  assign req_rise  = req_r && !req_p;
  assign busy_d    = state_d inside {FLUSH, WAIT_IDLE, WAIT_SOF, CAPTURE};
  assign done_d    = state_d == DONE;
  assign status_d  = {pw_d, 6'b0, busy_d, size_d, ovf_d, done_d, state_d};
  assign fifo_wr_enable   = wr_q;
  assign fifo_data_in     = data_q;
  assign fifo_write_reset = frst_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign status           = status_q;
  // Input stage plus one-cycle-older copies for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {fv_r, lv_r, pv_r, req_r, fv_p, lv_p, req_p} <= '0;
      pix_r <= '0;
    end else begin
      {fv_r, lv_r, pv_r, req_r} <= {frame_valid, line_valid, pixel_valid, cap_req};
      {fv_p, lv_p, req_p} <= {fv_r, lv_r, req_r};
      pix_r <= pixel;
    end
  // Next-state: flush sequencing, frame lock, pixel acceptance and sticky flags
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    to_idle_d = to_idle_q;
    col_d     = col_q;
    line_d    = line_q;
    pw_d      = pw_q;
    ovf_d     = ovf_q;
    size_d    = size_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    frst_d    = 1'b0;
    if (state_q == FLUSH) begin
      flush_d   = flush_q + FW'(1);
      frst_d    = flush_q != FLUSH_LAST;
      to_idle_d = to_idle_q | cap_abort;
      if (flush_q == FLUSH_LAST) state_d = (to_idle_q | cap_abort) ? IDLE : WAIT_IDLE;
    end else if (cap_abort) begin
      state_d = IDLE;
    end else if ((state_q == IDLE || state_q == DONE) && req_rise) begin
      state_d   = FLUSH;
      flush_d   = '0;
      to_idle_d = 1'b0;
      frst_d    = 1'b1;
      col_d     = '0;
      line_d    = '0;
      pw_d      = '0;
      ovf_d     = 1'b0;
      size_d    = 1'b0;
    end else begin
      if (state_q == WAIT_IDLE && !fv_r) state_d = WAIT_SOF;
      if (state_q == WAIT_SOF && fv_r) state_d = CAPTURE;
      if (accept) begin
        col_d = col_q + {15'b0, ~&col_q};
        if (!in_range) size_d = 1'b1;
        else if (fifo_full) ovf_d = 1'b1;
        else begin
          wr_d   = 1'b1;
          data_d = {22'b0, pix_r, 2'b00};
          pw_d   = pw_q + {18'b0, pw_q != PW_MAX};
        end
      end
      if (line_end && col_d != '0) begin
        line_d = line_q + {15'b0, ~&line_q};
        col_d  = '0;
        if (col_q != H_END) size_d = 1'b1;
      end
      if (frame_end) begin
        state_d = DONE;
        if (line_d != V_END) size_d = 1'b1;
      end
    end
  end
  // State and registered outputs; reset enters a FLUSH that falls back to IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= FLUSH;
      flush_q   <= '0;
      to_idle_q <= 1'b1;
      frst_q    <= 1'b1;
      col_q     <= '0;
      line_q    <= '0;
      pw_q      <= '0;
      ovf_q     <= 1'b0;
      size_q    <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      to_idle_q <= to_idle_d;
      frst_q    <= frst_d;
      col_q     <= col_d;
      line_q    <= line_d;
      pw_q      <= pw_d;
      ovf_q     <= ovf_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
endmodule

// File: tb/tb_frame_capture_writer.sv
// tb_frame_capture_writer: directed frames checked against a frame-level expected write stream
module tb_frame_capture_writer;
  localparam int H = 4;
  localparam int V = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cap_req = 1'b0, cap_abort = 1'b0;
  logic frame_valid = 1'b0, line_valid = 1'b0, pixel_valid = 1'b0, fifo_full = 1'b0;
  logic [7:0] pixel = '0;
  logic fifo_wr_enable, fifo_write_reset, busy, done;
  logic [31:0] fifo_data_in, status;
  int nvec = 0, nerr = 0, cyc = 0, nwr = 0, nrst = 0, w0 = 0;
  bit exp_wr [8192];
  bit [31:0] exp_dat [8192];
  logic [18:0] m_pw = '0;
  logic m_ovf = 1'b0, m_size = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  logic [2:0] m_state = 3'd0;

  frame_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .RST_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .cap_req(cap_req), .cap_abort(cap_abort),
    .frame_valid(frame_valid), .line_valid(line_valid), .pixel_valid(pixel_valid),
    .pixel(pixel), .fifo_full(fifo_full), .fifo_wr_enable(fifo_wr_enable),
    .fifo_data_in(fifo_data_in), .fifo_write_reset(fifo_write_reset),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock; every cycle the write port is compared against the expected stream
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("wr_en", {31'b0, fifo_wr_enable}, {31'b0, exp_wr[cyc]});
    if (exp_wr[cyc]) chk("wr_data", fifo_data_in, exp_dat[cyc]);
    if (fifo_wr_enable) nwr++;
    if (fifo_write_reset) nrst++;
  endtask

  function automatic logic [31:0] m_status();
    return {m_pw, 6'b0, m_busy, m_size, m_ovf, m_done, m_state};
  endfunction

  task automatic m_clear();
    m_pw = '0; m_ovf = 1'b0; m_size = 1'b0; m_done = 1'b0; m_state = 3'd1; m_busy = 1'b1;
  endtask

  // Fresh request edge; the FIFO reset pulse must last exactly four cycles
  task automatic arm();
    cap_req = 1'b0;
    step(); step();
    cap_req = 1'b1;
    m_clear();
    nrst = 0;
    for (int i = 0; i < 8; i++) step();
    chk("flush_len", nrst, 4);
  endtask

  // One frame of nl lines (line long_l one pixel too wide); pixel k carries value k.
  // fifo_full is presented while the FSM sees pixels full_lo..full_hi.
  task automatic frame(input int nl, input int long_l, input int full_lo, input int full_hi,
                       input int req_l, input int abort_k, input bit cap_in);
    bit cap = cap_in;
    bit nf = 1'b0;
    bit sz = 1'b0;
    int k = 0;
    frame_valid = 1'b1; line_valid = 1'b0; pixel_valid = 1'b0; fifo_full = 1'b0;
    step();
    for (int l = 0; l < nl; l++) begin
      int w;
      w = (l == long_l) ? H + 1 : H;
      if (w != H) sz = 1'b1;
      for (int c = 0; c < w; c++) begin
        k++;
        if (l == req_l && c == 0) begin
          cap_req = 1'b1;
          m_clear();
        end
        line_valid = 1'b1; pixel_valid = 1'b1; pixel = 8'(k); fifo_full = nf;
        nf = (k >= full_lo && k <= full_hi);
        if (cap) begin
          if (c >= H || l >= V) m_size = 1'b1;
          else if (nf) m_ovf = 1'b1;
          else begin
            exp_wr[cyc + 2] = 1'b1;
            exp_dat[cyc + 2] = {22'b0, pixel, 2'b00};
            m_pw++;
          end
        end
        if (k == abort_k) begin
          cap_abort = 1'b1;
          for (int i = 1; i <= 3; i++)
            if (exp_wr[cyc + i]) begin
              exp_wr[cyc + i] = 1'b0;
              m_pw--;
            end
          cap = 1'b0; m_state = 3'd0; m_busy = 1'b0; m_done = 1'b0;
        end
        step();
        if (k == abort_k) begin
          cap_abort = 1'b0;
          chk("abort_state", {29'b0, status[2:0]}, 32'd0);
          chk("abort_busy", {31'b0, busy}, 32'd0);
        end
      end
      line_valid = 1'b0; pixel_valid = 1'b0; fifo_full = nf; nf = 1'b0;
      step();
      fifo_full = 1'b0;
      step();
    end
    if (nl != V) sz = 1'b1;
    if (cap) begin
      m_size = m_size | sz; m_done = 1'b1; m_state = 3'd5; m_busy = 1'b0;
    end
    frame_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic end_checks(input string nm, input int writes, input logic [31:0] lit);
    chk({nm, "_writes"}, nwr - w0, writes);
    chk({nm, "_status"}, status, m_status());
    chk({nm, "_status_lit"}, status, lit);
    chk({nm, "_done"}, {31'b0, done}, {31'b0, m_done});
    chk({nm, "_busy"}, {31'b0, busy}, {31'b0, m_busy});
  endtask

  initial begin
    step(); step(); step();
    chk("rst_status", status, 32'h0);
    chk("rst_fifo_reset", {31'b0, fifo_write_reset}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    nrst = fifo_write_reset ? 1 : 0;
    for (int i = 0; i < 8; i++) step();
    chk("rel_flush_len", nrst, 4);
    chk("rel_status", status, 32'h0);
    chk("rel_busy", {31'b0, busy}, 32'd0);

    arm();
    w0 = nwr;
    frame(3, -1, 0, -1, -1, 0, 1'b1);
    end_checks("nominal", 12, 32'h0001_800D);

    cap_req = 1'b0;
    step(); step();
    w0 = nwr;
    frame(3, -1, 0, -1, 1, 0, 1'b0);
    chk("midframe_writes", nwr - w0, 0);
    w0 = nwr;
    frame(3, -1, 0, -1, -1, 0, 1'b1);
    end_checks("next_frame", 12, 32'h0001_800D);

    arm();
    w0 = nwr;
    frame(3, -1, 5, 6, -1, 0, 1'b1);
    end_checks("backpressure", 10, 32'h0001_401D);

    arm();
    w0 = nwr;
    frame(3, 1, 0, -1, -1, 0, 1'b1);
    end_checks("wide_line", 12, 32'h0001_802D);

    arm();
    w0 = nwr;
    frame(2, -1, 0, -1, -1, 0, 1'b1);
    end_checks("short_frame", 8, 32'h0001_002D);

    arm();
    w0 = nwr;
    frame(3, -1, 0, -1, -1, 6, 1'b1);
    end_checks("abort", 4, 32'h0000_8000);

    cap_req = 1'b0;
    step(); step();
    nrst = 0;
    cap_req = 1'b1;
    cap_abort = 1'b1;
    step(); step(); step();
    cap_abort = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("req_abort_flush", nrst, 0);
    chk("req_abort_status", status, m_status());
    chk("req_abort_status_lit", status, 32'h0000_8000);
    chk("req_abort_busy", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/frame_capture_writer.md
Name: frame_capture_writer

Overview:
Upstream feeder of the USB block-throttled pipe FIFO. On a PC capture request it flushes the FIFO, locks to the next camera frame start, and writes one active frame of 8-bit pixels into the FIFO write port. Each pixel is written as one word, with the pixel in bits [9:2]. A sticky status word is exported for a PC wire-out endpoint.

Parameters:
H_ACTIVE, 640, pixels per active line
V_ACTIVE, 480, active lines per frame
RST_CYCLES, 8, cycles fifo_write_reset is held high per flush (>=1)

Ports:
clk  in  1  pixel clock; also the FIFO write clock
reset_n  in  1  asynchronous, active-low reset
cap_req  in  1  capture request level from a PC command bit; rising edge acts
cap_abort  in  1  level; forces IDLE
frame_valid  in  1  camera frame strobe
line_valid  in  1  camera line strobe
pixel_valid  in  1  camera pixel qualifier
pixel  in  8  camera pixel
fifo_full  in  1  FIFO full flag
fifo_wr_enable  out  1  FIFO write enable
fifo_data_in  out  32  FIFO write data, {22'b0, pixel, 2'b00}
fifo_write_reset  out  1  active-high FIFO write-side reset
busy  out  1  high in FLUSH, WAIT_IDLE, WAIT_SOF, CAPTURE
done  out  1  high in DONE
status  out  32  [2:0] state code, [3] done, [4] overflow, [5] size_err, [6] busy, [12:7] 0, [31:13] pixels_written

Behaviour:
- Input stage: frame_valid, line_valid, pixel_valid, pixel and cap_req are registered once (_r). The FSM uses only registered values.
- A pixel at the inputs in cycle n appears as fifo_wr_enable/fifo_data_in in cycle n+2. Both outputs are registered.
- State codes: IDLE=0, FLUSH=1, WAIT_IDLE=2, WAIT_SOF=3, CAPTURE=4, DONE=5.
- Reset (reset_n=0):
  - state=FLUSH, flush counter=0, fifo_write_reset=1.
  - All other outputs 0; overflow, size_err, pixels_written, column and line counters 0.
  - After release, FLUSH runs RST_CYCLES cycles, then IDLE.
- IDLE/DONE + cap_req_r rising edge -> FLUSH:
  - clear overflow, size_err, pixels_written and the counters.
  - fifo_write_reset=1 for exactly RST_CYCLES cycles, then WAIT_IDLE.
- cap_req edges in FLUSH, WAIT_IDLE, WAIT_SOF and CAPTURE are ignored.
- WAIT_IDLE: go to WAIT_SOF once frame_valid_r=0. A frame already in progress is never partially captured.
- WAIT_SOF: on frame_valid_r=1 go to CAPTURE. A qualified pixel in that same cycle is accepted.
- Pixel acceptance: (CAPTURE, or WAIT_SOF with frame_valid_r) AND line_valid_r AND pixel_valid_r.
- Column counter: increments per accepted pixel.
  - Column index >= H_ACTIVE -> pixel dropped, size_err=1.
  - Line index >= V_ACTIVE -> pixel dropped, size_err=1.
- Line counter: increments on a line_valid_r falling edge in CAPTURE, only if column>0. Column resets to 0 on that edge.
- Accepted, in-range pixel:
  - fifo_full=0 -> write, pixels_written+1.
  - fifo_full=1 -> no write, overflow=1 (sticky); column still advances.
- pixels_written saturates at 2^19-1.
- CAPTURE + frame_valid_r falling edge -> DONE. In that cycle, size_err|=(any line width !=H_ACTIVE) or (lines !=V_ACTIVE).
- DONE holds flags and pixels_written until the next request edge.
- cap_abort=1 in any state except FLUSH:
  - next state IDLE; fifo_wr_enable=0 next cycle; the in-flight pipeline word is discarded.
  - flags are retained.
- cap_abort=1 in FLUSH: FLUSH completes, then IDLE.
- cap_req edge and cap_abort in the same cycle: abort wins.

Test Plan:
Parameters for all tests: H_ACTIVE=4, V_ACTIVE=3, RST_CYCLES=4.
1. Reset: release reset_n -> fifo_write_reset=1 for exactly 4 cycles, then status=0x00000000 and busy=0.
2. Nominal: req edge, then a 3x4 frame with pixels 0x01..0x0C:
   - 12 writes in order, data 0x004,0x008..0x030, each 2 cycles after input.
   - done=1, status[31:13]=12, overflow=0, size_err=0, state=5.
3. Mid-frame arm: request while frame_valid=1 -> zero writes for that frame; the next frame is captured fully (12 writes).
4. Backpressure: fifo_full=1 during pixels 5-6 -> 10 writes (pixels 5,6 absent), overflow=1, pixels_written=10, done=1.
5. Size errors:
   - a line with 5 pixels -> 5th not written, size_err=1.
   - a separate frame with 2 lines -> 8 writes, size_err=1, done=1.
6. Abort:
   - cap_abort mid-line -> fifo_wr_enable=0 from the next cycle, state=0, busy=0.
   - req edge together with abort -> remains IDLE, no fifo_write_reset pulse.
